// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NUM_READ = 2;
  localparam int DEF_TAP_REG  = 6;

  // Ceiling log2; evaluated at elaboration to size address fields.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a population counter.
// An issue and a writeback to the same register in one cycle leave it busy,
// because the newly issued instruction now owns that destination.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_count
);

  logic [DEPTH-1:0] busy_d, busy_q;
  logic [ADDR_W:0]  count_d, count_q;
  logic             set_s, wr_s, clr_s, inc_s, dec_s;

  // Next-state busy vector and counter; register 0 can never be set or cleared.
  always_comb begin
    busy_d = busy_q;
    set_s  = issue_en && (issue_reg != {ADDR_W{1'b0}});
    wr_s   = wr_en && (wr_reg != {ADDR_W{1'b0}});
    clr_s  = wr_s && !(set_s && (issue_reg == wr_reg));
    inc_s  = set_s && !busy_q[issue_reg];
    dec_s  = clr_s && busy_q[wr_reg];
    if (clr_s) begin
      busy_d[wr_reg] = 1'b0;
    end else begin
      busy_d[wr_reg] = busy_q[wr_reg];
    end
    if (set_s) begin
      busy_d[issue_reg] = 1'b1;
    end else begin
      busy_d[issue_reg] = busy_d[issue_reg];
    end
    count_d = count_q + {{ADDR_W{1'b0}}, inc_s} - {{ADDR_W{1'b0}}, dec_s};
  end

  // Busy bits and counter advance together so the count always equals the popcount.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      busy_q  <= {DEPTH{1'b0}};
      count_q <= {(ADDR_W + 1){1'b0}};
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy       = busy_q;
  assign busy_count = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-first bypass, hardwired zero register, debug tap
// and a pending-write scoreboard for decode-stage hazard detection.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_READ = DEF_NUM_READ,
  parameter int TAP_REG  = DEF_TAP_REG,
  parameter int ADDR_W   = clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         ctrl_reset_n,
  input  logic                         ctrl_writeEnable,
  input  logic [ADDR_W-1:0]            ctrl_writeReg,
  input  logic [DATA_W-1:0]            data_writeReg,
  input  logic                         ctrl_issueEnable,
  input  logic [ADDR_W-1:0]            ctrl_issueReg,
  input  logic [NUM_READ*ADDR_W-1:0]   ctrl_readReg,
  output logic [NUM_READ*DATA_W-1:0]   data_readReg,
  output logic [NUM_READ-1:0]          busy_read,
  output logic [ADDR_W:0]              busy_count,
  output logic [DATA_W-1:0]            data_tap
);

  localparam logic [ADDR_W-1:0] TAP_IDX = ADDR_W'(TAP_REG);

  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_s;

  // Next-state storage image: a writeback to any register except 0 lands.
  always_comb begin
    regs_d = regs_q;
    if (ctrl_writeEnable && (ctrl_writeReg != {ADDR_W{1'b0}})) begin
      regs_d[ctrl_writeReg] = data_writeReg;
    end else begin
      regs_d[ctrl_writeReg] = regs_q[ctrl_writeReg];
    end
  end

  // Storage array, cleared asynchronously.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= {DATA_W{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .issue_en     (ctrl_issueEnable),
    .issue_reg    (ctrl_issueReg),
    .wr_en        (ctrl_writeEnable),
    .wr_reg       (ctrl_writeReg),
    .busy         (busy_s),
    .busy_count   (busy_count)
  );

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic              hit_s;
    logic [DATA_W-1:0] rd_s;

    assign addr_s = ctrl_readReg[i*ADDR_W +: ADDR_W];
    assign hit_s  = ctrl_writeEnable && (ctrl_writeReg == addr_s);

    // Read mux: zero register first, then same-cycle writeback, then storage.
    always_comb begin
      if (addr_s == {ADDR_W{1'b0}}) begin
        rd_s = {DATA_W{1'b0}};
      end else if (hit_s) begin
        rd_s = data_writeReg;
      end else begin
        rd_s = regs_q[addr_s];
      end
    end

    assign data_readReg[i*DATA_W +: DATA_W] = rd_s;
    // A writeback in this cycle satisfies the reader through the bypass.
    assign busy_read[i] = busy_s[addr_s] & ~hit_s;
  end

  assign data_tap = regs_q[TAP_IDX];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default configuration plus a 16x16, 3-port variant.
module tb_regfile_sb;

  logic clock = 1'b0;
  logic ctrl_reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: DATA_W=32, DEPTH=32, NUM_READ=2
  logic        wa_en = 1'b0;
  logic [4:0]  wa_reg = 5'd0;
  logic [31:0] wa_data = 32'd0;
  logic        ia_en = 1'b0;
  logic [4:0]  ia_reg = 5'd0;
  logic [9:0]  ra = 10'd0;
  logic [63:0] rda;
  logic [1:0]  bra;
  logic [5:0]  cnta;
  logic [31:0] tapa;

  // Instance B: DATA_W=16, DEPTH=16, NUM_READ=3
  logic        wb_en = 1'b0;
  logic [3:0]  wb_reg = 4'd0;
  logic [15:0] wb_data = 16'd0;
  logic        ib_en = 1'b0;
  logic [3:0]  ib_reg = 4'd0;
  logic [11:0] rb = 12'd0;
  logic [47:0] rdb;
  logic [2:0]  brb;
  logic [4:0]  cntb;
  logic [15:0] tapb;

  regfile_sb u_dut_a (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (wa_en),
    .ctrl_writeReg    (wa_reg),
    .data_writeReg    (wa_data),
    .ctrl_issueEnable (ia_en),
    .ctrl_issueReg    (ia_reg),
    .ctrl_readReg     (ra),
    .data_readReg     (rda),
    .busy_read        (bra),
    .busy_count       (cnta),
    .data_tap         (tapa)
  );

  regfile_sb #(
    .DATA_W   (16),
    .DEPTH    (16),
    .NUM_READ (3)
  ) u_dut_b (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (wb_en),
    .ctrl_writeReg    (wb_reg),
    .data_writeReg    (wb_data),
    .ctrl_issueEnable (ib_en),
    .ctrl_issueReg    (ib_reg),
    .ctrl_readReg     (rb),
    .data_readReg     (rdb),
    .busy_read        (brb),
    .busy_count       (cntb),
    .data_tap         (tapb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_rd_a", rda, 64'd0);
    check("rst_busy_a", {62'd0, bra}, 64'd0);
    check("rst_cnt_a", {58'd0, cnta}, 64'd0);
    check("rst_tap_a", {32'd0, tapa}, 64'd0);
    step();
    ctrl_reset_n = 1'b1;
    step();

    // Write/read r5 on both ports
    wa_en = 1'b1; wa_reg = 5'd5; wa_data = 32'hDEADBEEF;
    step();
    wa_en = 1'b0; ra = {5'd5, 5'd5};
    #1;
    check("wr_r5_both", rda, 64'hDEADBEEF_DEADBEEF);
    // Write to r0 dropped, even through bypass
    wa_en = 1'b1; wa_reg = 5'd0; wa_data = 32'h00001234; ra = {5'd5, 5'd0};
    #1;
    check("r0_bypass", rda, {32'hDEADBEEF, 32'd0});
    step();
    wa_en = 1'b0;
    #1;
    check("r0_stored", rda, {32'hDEADBEEF, 32'd0});

    // Bypass: r9 old 0x11, r8 = 0x88
    wa_en = 1'b1; wa_reg = 5'd9; wa_data = 32'h00000011;
    step();
    wa_reg = 5'd8; wa_data = 32'h00000088;
    step();
    wa_reg = 5'd9; wa_data = 32'hA5A5A5A5; ra = {5'd8, 5'd9};
    #1;
    check("bypass_r9", rda, {32'h00000088, 32'hA5A5A5A5});
    step();
    wa_en = 1'b0;
    #1;
    check("stored_r9", rda, {32'h00000088, 32'hA5A5A5A5});

    // Scoreboard: issue r3, r4
    ia_en = 1'b1; ia_reg = 5'd3;
    step();
    ia_reg = 5'd4;
    step();
    ia_en = 1'b0; ra = {5'd4, 5'd3};
    #1;
    check("sb_cnt2", {58'd0, cnta}, 64'd2);
    check("sb_busy34", {62'd0, bra}, 64'd3);
    wa_en = 1'b1; wa_reg = 5'd3; wa_data = 32'h00000033;
    #1;
    check("sb_wr3_busy", {62'd0, bra}, 64'd2);
    check("sb_wr3_cnt_pre", {58'd0, cnta}, 64'd2);
    step();
    wa_en = 1'b0;
    #1;
    check("sb_wr3_cnt", {58'd0, cnta}, 64'd1);
    check("sb_wr3_data", rda[31:0], 64'h33);

    // Simultaneous issue+write on busy r7
    ia_en = 1'b1; ia_reg = 5'd7;
    step();
    ia_en = 1'b0; ra = {5'd4, 5'd7};
    #1;
    check("sb_r7_cnt", {58'd0, cnta}, 64'd2);
    ia_en = 1'b1; wa_en = 1'b1; wa_reg = 5'd7; wa_data = 32'h00000077;
    #1;
    check("sim_busy_in", {62'd0, bra}, 64'd2);
    step();
    ia_en = 1'b0; wa_en = 1'b0;
    #1;
    check("sim_cnt", {58'd0, cnta}, 64'd2);
    check("sim_busy", {62'd0, bra}, 64'd3);
    check("sim_data", rda[31:0], 64'h77);
    // Issue r0 and re-issue busy r4: no change
    ia_en = 1'b1; ia_reg = 5'd0;
    step();
    ia_reg = 5'd4;
    step();
    ia_en = 1'b0;
    #1;
    check("iss_r0_r4_cnt", {58'd0, cnta}, 64'd2);
    // Issue r10 and write r4 together: net zero
    ia_en = 1'b1; ia_reg = 5'd10; wa_en = 1'b1; wa_reg = 5'd4; wa_data = 32'h00000044;
    step();
    ia_en = 1'b0; wa_en = 1'b0; ra = {5'd10, 5'd4};
    #1;
    check("net0_cnt", {58'd0, cnta}, 64'd2);
    check("net0_busy", {62'd0, bra}, 64'd2);

    // Tap on r6
    wa_en = 1'b1; wa_reg = 5'd6; wa_data = 32'h00000042;
    #1;
    check("tap_same_cycle", {32'd0, tapa}, 64'd0);
    step();
    wa_en = 1'b0;
    #1;
    check("tap_after", {32'd0, tapa}, 64'h42);

    // Asynchronous reset mid-run
    ra = {5'd7, 5'd5};
    #1;
    check("pre_rst_rd", rda, {32'h00000077, 32'hDEADBEEF});
    ctrl_reset_n = 1'b0;
    #1;
    check("mid_rst_rd", rda, 64'd0);
    check("mid_rst_busy", {62'd0, bra}, 64'd0);
    check("mid_rst_cnt", {58'd0, cnta}, 64'd0);
    check("mid_rst_tap", {32'd0, tapa}, 64'd0);
    step();
    ctrl_reset_n = 1'b1;
    step();
    check("post_rst_rd", rda, 64'd0);

    // Instance B: write/read r5 on three ports
    wb_en = 1'b1; wb_reg = 4'd5; wb_data = 16'hBEEF;
    step();
    wb_en = 1'b0; rb = {4'd5, 4'd5, 4'd5};
    #1;
    check("b_wr_r5", {16'd0, rdb}, {16'd0, 48'hBEEF_BEEF_BEEF});
    wb_en = 1'b1; wb_reg = 4'd0; wb_data = 16'h1234; rb = {4'd0, 4'd5, 4'd0};
    step();
    wb_en = 1'b0;
    #1;
    check("b_r0", {16'd0, rdb}, {16'd0, 48'h0000_BEEF_0000});
    // Bypass
    wb_en = 1'b1; wb_reg = 4'd9; wb_data = 16'h0011;
    step();
    wb_reg = 4'd8; wb_data = 16'h0088;
    step();
    wb_reg = 4'd9; wb_data = 16'hA5A5; rb = {4'd9, 4'd8, 4'd9};
    #1;
    check("b_bypass", {16'd0, rdb}, {16'd0, 48'hA5A5_0088_A5A5});
    step();
    wb_en = 1'b0;
    // Scoreboard
    ib_en = 1'b1; ib_reg = 4'd3;
    step();
    ib_reg = 4'd4;
    step();
    ib_en = 1'b0; rb = {4'd3, 4'd4, 4'd3};
    #1;
    check("b_cnt2", {59'd0, cntb}, 64'd2);
    check("b_busy", {61'd0, brb}, 64'd7);
    wb_en = 1'b1; wb_reg = 4'd3; wb_data = 16'h0033;
    #1;
    check("b_wr3_busy", {61'd0, brb}, 64'd2);
    step();
    wb_en = 1'b0;
    #1;
    check("b_wr3_cnt", {59'd0, cntb}, 64'd1);
    check("b_tap", {48'd0, tapb}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
